// File: rtl/cdf_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : cdf_pkg
//  Description : Shared types and default widths for the CDF sequencer and
//                its bus interface.
//                  - cdf_state_t : sequencer FSM state encoding
//                  - CDF_DATA_W  : default bin-count / accumulate width
//                  - CDF_ADDR_W  : default histogram / store address width
//                  - CDF_BINS    : default number of histogram bins per frame
//  Revision    : 1.0  initial release
// ============================================================================
package cdf_pkg;

   localparam int CDF_DATA_W = 20;
   localparam int CDF_ADDR_W = 16;
   localparam int CDF_BINS   = 256;

   typedef enum logic [2:0] {
      S_IDLE    = 3'd0,
      S_READ    = 3'd1,
      S_DRAIN   = 3'd2,
      S_CAPTURE = 3'd3,
      S_DONE    = 3'd4
   } cdf_state_t;

endpackage : cdf_pkg
`default_nettype wire

// File: rtl/cdf_sequencer_if.sv
`default_nettype none
// ============================================================================
//  Module      : cdf_sequencer_if
//  Description : Bundle of the control, histogram-RAM, accumulate-stage and
//                result signals of the CDF sequencer.
//                  control : start, abort (in)  busy, done (out)
//                  hist    : hist_rd_en, hist_rd_addr (out) hist_rd_data (in)
//                  acc     : acc_in, acc_start, acc_store_addr (out)
//                            acc_result, acc_cdf_min, acc_cdf_valid (in)
//                  result  : cdf_total, cdf_min, cdf_min_valid (out)
//                Directions above are as seen by the sequencer (master).
//                The slave modport is the surrounding pipeline.
//  Revision    : 1.0  initial release
// ============================================================================
interface cdf_sequencer_if
   import cdf_pkg::*;
#(
   parameter int ADDR_W = CDF_ADDR_W,
   parameter int DATA_W = CDF_DATA_W
);

   logic              start;
   logic              abort;
   logic              busy;
   logic              done;

   logic              hist_rd_en;
   logic [ADDR_W-1:0] hist_rd_addr;
   logic [DATA_W-1:0] hist_rd_data;

   logic [DATA_W-1:0] acc_in;
   logic              acc_start;
   logic [ADDR_W-1:0] acc_store_addr;
   logic [DATA_W-1:0] acc_result;
   logic [DATA_W-1:0] acc_cdf_min;
   logic              acc_cdf_valid;

   logic [DATA_W-1:0] cdf_total;
   logic [DATA_W-1:0] cdf_min;
   logic              cdf_min_valid;

   modport master (
      input  start, abort,
      input  hist_rd_data,
      input  acc_result, acc_cdf_min, acc_cdf_valid,
      output busy, done,
      output hist_rd_en, hist_rd_addr,
      output acc_in, acc_start, acc_store_addr,
      output cdf_total, cdf_min, cdf_min_valid
   );

   modport slave (
      output start, abort,
      output hist_rd_data,
      output acc_result, acc_cdf_min, acc_cdf_valid,
      input  busy, done,
      input  hist_rd_en, hist_rd_addr,
      input  acc_in, acc_start, acc_store_addr,
      input  cdf_total, cdf_min, cdf_min_valid
   );

endinterface : cdf_sequencer_if
`default_nettype wire

// File: rtl/cdf_sequencer.sv
`default_nettype none
// ============================================================================
//  Module      : cdf_sequencer
//  Description : Sequencing controller for the CDF accumulate stage. On start
//                it reads bins 0..BINS-1 from the histogram RAM (one per
//                cycle), presents them to the accumulate stage one cycle later
//                together with the start qualifier and store address, then
//                captures the final cumulative total and the first non-zero
//                CDF value and pulses done.
//  Ports       : clock, reset         - clock, synchronous active-high reset
//                bus (master)         - control / RAM / accumulate / result
//                frame_count [15:0]   - completed-sweep counter, only present
//                                       when CDF_SEQ_FRAME_CNT_EN is defined
//  Options     : CDF_SEQ_FRAME_CNT_EN - adds frame_count output and counter
//  Revision    : 1.0  initial release
// ============================================================================
module cdf_sequencer
   import cdf_pkg::*;
#(
   parameter int BINS   = CDF_BINS,
   parameter int ADDR_W = CDF_ADDR_W,
   parameter int DATA_W = CDF_DATA_W
) (
   input  wire logic        clock,
   input  wire logic        reset,
   cdf_sequencer_if.master  bus
`ifdef CDF_SEQ_FRAME_CNT_EN
   ,
   output logic [15:0]      frame_count
`endif
);

   localparam logic [ADDR_W-1:0] C_LAST_ADDR = ADDR_W'(BINS - 1);

   cdf_state_t        r_state;
   cdf_state_t        w_state_next;

   logic              r_busy;
   logic              r_done;
   logic              r_rd_en;
   logic [ADDR_W-1:0] r_rd_addr;
   logic              r_acc_start;
   logic [ADDR_W-1:0] r_store_addr;
   logic [DATA_W-1:0] r_cdf_total;
   logic [DATA_W-1:0] r_cdf_min;
   logic              r_cdf_min_valid;

   // cdf_min of the sweep in flight is held in a shadow register and only
   // published at CAPTURE, so an aborted sweep leaves the previous sweep's
   // cdf_min visible while an all-zero sweep still publishes zero.
   logic              r_min_taken;
   logic [DATA_W-1:0] r_min_shadow;

   logic              w_sweep_start;
   logic              w_abort;
   logic              w_min_hit;
   logic [DATA_W-1:0] w_min_value;

   assign w_sweep_start = (r_state == S_IDLE) && bus.start;
   assign w_abort       = bus.abort && ((r_state == S_READ) || (r_state == S_DRAIN));

   // First acc_cdf_valid pulse of the sweep; the bypass lets a pulse that
   // lands in the CAPTURE cycle itself (non-zero only in the last bin) be
   // published together with the total.
   assign w_min_hit   = bus.acc_cdf_valid && !r_min_taken && (r_state != S_IDLE);
   assign w_min_value = w_min_hit ? bus.acc_cdf_min : r_min_shadow;

   // ------------------------------------------------------------------------
   // Next-state logic
   // ------------------------------------------------------------------------
   always_comb begin
      w_state_next = r_state;
      case (r_state)
         S_IDLE: begin
            if (bus.start) begin
               w_state_next = S_READ;
            end
         end
         S_READ: begin
            if (bus.abort) begin
               w_state_next = S_IDLE;
            end else if (r_rd_addr == C_LAST_ADDR) begin
               w_state_next = S_DRAIN;
            end
         end
         S_DRAIN: begin
            if (bus.abort) begin
               w_state_next = S_IDLE;
            end else begin
               w_state_next = S_CAPTURE;
            end
         end
         S_CAPTURE: w_state_next = S_DONE;
         S_DONE:    w_state_next = S_IDLE;
         default:   w_state_next = S_IDLE;
      endcase
   end

   // ------------------------------------------------------------------------
   // State register and registered outputs
   // ------------------------------------------------------------------------
   always_ff @(posedge clock) begin
      if (reset) begin
         r_state         <= S_IDLE;
         r_busy          <= 1'b0;
         r_done          <= 1'b0;
         r_rd_en         <= 1'b0;
         r_rd_addr       <= '0;
         r_acc_start     <= 1'b0;
         r_store_addr    <= '0;
         r_cdf_total     <= '0;
         r_cdf_min       <= '0;
         r_cdf_min_valid <= 1'b0;
         r_min_taken     <= 1'b0;
         r_min_shadow    <= '0;
      end else begin
         r_state <= w_state_next;

         // Decoded from the next state so the outputs line up with the
         // state they describe while still coming straight from flops.
         r_busy  <= (w_state_next != S_IDLE);
         r_done  <= (w_state_next == S_DONE);
         r_rd_en <= (w_state_next == S_READ);

         if (w_state_next == S_READ) begin
            r_rd_addr <= (r_state == S_READ) ? r_rd_addr + 1'b1 : '0;
         end else begin
            r_rd_addr <= '0;
         end

         // One-cycle delay matching the RAM read latency.
         r_acc_start  <= r_rd_en;
         r_store_addr <= r_rd_addr;

         if (w_sweep_start) begin
            r_min_taken  <= 1'b0;
            r_min_shadow <= '0;
         end else if (w_min_hit) begin
            r_min_taken  <= 1'b1;
            r_min_shadow <= bus.acc_cdf_min;
         end

         if (w_sweep_start || w_abort) begin
            r_cdf_min_valid <= 1'b0;
         end else if (r_state == S_CAPTURE) begin
            r_cdf_min_valid <= r_min_taken || w_min_hit;
         end

         // acc_result holds the full sum during CAPTURE; the accumulator
         // clears on the same edge because acc_start is already low.
         if (r_state == S_CAPTURE) begin
            r_cdf_total <= bus.acc_result;
            r_cdf_min   <= w_min_value;
         end
      end
   end

   assign bus.busy           = r_busy;
   assign bus.done           = r_done;
   assign bus.hist_rd_en     = r_rd_en;
   assign bus.hist_rd_addr   = r_rd_addr;
   assign bus.acc_start      = r_acc_start;
   assign bus.acc_store_addr = r_store_addr;
   assign bus.cdf_total      = r_cdf_total;
   assign bus.cdf_min        = r_cdf_min;
   assign bus.cdf_min_valid  = r_cdf_min_valid;

   // RAM read data arrives from the RAM's own output register in the same
   // cycle as acc_start; it is gated so acc_in is zero whenever no bin is
   // being presented (including straight out of reset).
   assign bus.acc_in = r_acc_start ? bus.hist_rd_data : '0;

`ifdef CDF_SEQ_FRAME_CNT_EN
   // ------------------------------------------------------------------------
   // Completed-sweep counter; CAPTURE always leads to DONE, so counting on
   // the CAPTURE edge makes the new value visible alongside done.
   // ------------------------------------------------------------------------
   logic [15:0] r_frame_count;

   always_ff @(posedge clock) begin
      if (reset) begin
         r_frame_count <= '0;
      end else if (r_state == S_CAPTURE) begin
         r_frame_count <= r_frame_count + 16'd1;
      end
   end

   assign frame_count = r_frame_count;
`endif

endmodule : cdf_sequencer
`default_nettype wire

// File: tb/tb_cdf_sequencer.sv
`default_nettype none
// ============================================================================
//  Module      : tb_cdf_sequencer
//  Description : Directed self-checking bench for cdf_sequencer with BINS=4.
//                Models the histogram RAM (1-cycle read latency) and the
//                accumulate stage (registered running sum, first non-zero
//                cdf_min pulse). Frame counter checks are included when
//                CDF_SEQ_FRAME_CNT_EN is defined.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_cdf_sequencer;
   import cdf_pkg::*;

   localparam int BINS   = 4;
   localparam int ADDR_W = 16;
   localparam int DATA_W = 20;

   logic clock = 1'b0;
   logic reset = 1'b1;

   always #5 clock = ~clock;

   cdf_sequencer_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) bus ();

`ifdef CDF_SEQ_FRAME_CNT_EN
   logic [15:0] frame_count;
`endif

   cdf_sequencer #(
      .BINS   (BINS),
      .ADDR_W (ADDR_W),
      .DATA_W (DATA_W)
   ) dut (
      .clock (clock),
      .reset (reset),
      .bus   (bus)
`ifdef CDF_SEQ_FRAME_CNT_EN
      ,
      .frame_count (frame_count)
`endif
   );

   // ------------------------------------------------------------------------
   // Histogram RAM model
   // ------------------------------------------------------------------------
   logic [DATA_W-1:0] mem [BINS];

   always @(posedge clock) begin
      if (bus.hist_rd_en) begin
         bus.hist_rd_data <= mem[int'(bus.hist_rd_addr) % BINS];
      end
   end

   // ------------------------------------------------------------------------
   // Accumulate stage model
   // ------------------------------------------------------------------------
   logic m_min_seen = 1'b0;

   initial begin
      bus.acc_result    = '0;
      bus.acc_cdf_min   = '0;
      bus.acc_cdf_valid = 1'b0;
   end

   always @(posedge clock) begin : acc_model
      logic [DATA_W-1:0] nsum;
      nsum = bus.acc_result + bus.acc_in;
      if (!bus.acc_start) begin
         bus.acc_result    <= '0;
         bus.acc_cdf_valid <= 1'b0;
         m_min_seen        <= 1'b0;
      end else begin
         bus.acc_result <= nsum;
         if (nsum != '0 && !m_min_seen) begin
            bus.acc_cdf_min   <= nsum;
            bus.acc_cdf_valid <= 1'b1;
            m_min_seen        <= 1'b1;
         end else begin
            bus.acc_cdf_valid <= 1'b0;
         end
      end
   end

   // ------------------------------------------------------------------------
   // Shortest low run of acc_start between two high runs
   // ------------------------------------------------------------------------
   int   min_gap   = 1000;
   int   gap_run   = 0;
   logic seen_high = 1'b0;

   always @(negedge clock) begin
      if (bus.acc_start) begin
         if (seen_high && gap_run > 0 && gap_run < min_gap) min_gap = gap_run;
         seen_high = 1'b1;
         gap_run   = 0;
      end else begin
         gap_run = gap_run + 1;
      end
   end

   // ------------------------------------------------------------------------
   // Checking
   // ------------------------------------------------------------------------
   int n_checks = 0;
   int n_pass   = 0;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got === exp) begin
         n_pass++;
      end else begin
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
      end
   endtask

   task automatic load(input logic [DATA_W-1:0] b0, b1, b2, b3);
      mem[0] = b0;
      mem[1] = b1;
      mem[2] = b2;
      mem[3] = b3;
   endtask

   // Leaves the caller just after edge T (inside cycle T+1).
   task automatic start_pulse();
      @(negedge clock);
      bus.start = 1'b1;
      @(posedge clock);
      #1 bus.start = 1'b0;
   endtask

   // Samples cycles T+1..T+n. restart_k>0 re-asserts start during cycles
   // restart_k..restart_k+1 to show it is ignored while busy.
   task automatic watch(input int n, input int restart_k,
                        output int acc_hi, output int first_acc,
                        output int done_at, output int done_cnt,
                        output logic addr_ok,
                        output logic [DATA_W-1:0] tot_d,
                        output logic [DATA_W-1:0] min_d,
                        output logic val_d);
      acc_hi = 0; first_acc = 0; done_at = 0; done_cnt = 0; addr_ok = 1'b1;
      tot_d = '0; min_d = '0; val_d = 1'b0;
      for (int k = 1; k <= n; k++) begin
         @(negedge clock);
         if (bus.acc_start) begin
            if (first_acc == 0) first_acc = k;
            if (bus.acc_store_addr != ADDR_W'(acc_hi)) addr_ok = 1'b0;
            acc_hi++;
         end
         if (bus.done) begin
            done_cnt++;
            done_at = k;
            tot_d   = bus.cdf_total;
            min_d   = bus.cdf_min;
            val_d   = bus.cdf_min_valid;
         end
         if (restart_k != 0 && k == restart_k)     bus.start = 1'b1;
         if (restart_k != 0 && k == restart_k + 2) bus.start = 1'b0;
      end
   endtask

   task automatic check_reset_outputs(input string tag);
      check({tag, "_busy"},   32'(bus.busy), 0);
      check({tag, "_done"},   32'(bus.done), 0);
      check({tag, "_rd_en"},  32'(bus.hist_rd_en), 0);
      check({tag, "_rd_addr"},32'(bus.hist_rd_addr), 0);
      check({tag, "_acc_in"}, 32'(bus.acc_in), 0);
      check({tag, "_acc_st"}, 32'(bus.acc_start), 0);
      check({tag, "_st_addr"},32'(bus.acc_store_addr), 0);
      check({tag, "_total"},  32'(bus.cdf_total), 0);
      check({tag, "_min"},    32'(bus.cdf_min), 0);
      check({tag, "_minv"},   32'(bus.cdf_min_valid), 0);
`ifdef CDF_SEQ_FRAME_CNT_EN
      check({tag, "_frames"}, 32'(frame_count), 0);
`endif
   endtask

   // ------------------------------------------------------------------------
   // Stimulus
   // ------------------------------------------------------------------------
   int                acc_hi, first_acc, done_at, done_cnt;
   logic              addr_ok;
   logic [DATA_W-1:0] tot_d, min_d;
   logic              val_d;

   initial begin
      bus.start = 1'b0;
      bus.abort = 1'b0;
      load('0, '0, '0, '0);
      reset = 1'b1;
      repeat (3) @(negedge clock);
      check_reset_outputs("rst");
      reset = 1'b0;

      // Sweep A: {0,0,3,5}
      load(0, 0, 3, 5);
      start_pulse();
      watch(9, 0, acc_hi, first_acc, done_at, done_cnt, addr_ok, tot_d, min_d, val_d);
      check("a_acc_cycles", 32'(acc_hi), 4);
      check("a_acc_first",  32'(first_acc), 2);
      check("a_store_addr", 32'(addr_ok), 1);
      check("a_done_at",    32'(done_at), 7);
      check("a_done_cnt",   32'(done_cnt), 1);
      check("a_total",      32'(tot_d), 8);
      check("a_min",        32'(min_d), 3);
      check("a_minv",       32'(val_d), 1);
      check("a_idle",       32'(bus.busy), 0);

      // Sweep B: {1,1,1,1} aborted at T+2
      load(1, 1, 1, 1);
      start_pulse();
      @(negedge clock);
      check("b_busy_t1", 32'(bus.busy), 1);
      @(negedge clock);
      bus.abort = 1'b1;
      @(posedge clock);
      #1 bus.abort = 1'b0;
      @(negedge clock);
      check("b_busy_t3",  32'(bus.busy), 0);
      check("b_rd_en_t3", 32'(bus.hist_rd_en), 0);
      @(negedge clock);
      check("b_acc_st_t4", 32'(bus.acc_start), 0);
      watch(8, 0, acc_hi, first_acc, done_at, done_cnt, addr_ok, tot_d, min_d, val_d);
      check("b_no_done",  32'(done_cnt), 0);
      check("b_no_acc",   32'(acc_hi), 0);
      check("b_total",    32'(bus.cdf_total), 8);
      check("b_min",      32'(bus.cdf_min), 3);
      check("b_minv",     32'(bus.cdf_min_valid), 0);

      // Sweep C: all zero
      load(0, 0, 0, 0);
      start_pulse();
      watch(9, 0, acc_hi, first_acc, done_at, done_cnt, addr_ok, tot_d, min_d, val_d);
      check("c_done_at", 32'(done_at), 7);
      check("c_total",   32'(tot_d), 0);
      check("c_min",     32'(min_d), 0);
      check("c_minv",    32'(val_d), 0);

      // Sweep D: {2,0,0,0} with start re-asserted during READ, then E
      // {0,0,0,7} started at the earliest accepted cycle.
      load(2, 0, 0, 0);
      start_pulse();
      watch(7, 2, acc_hi, first_acc, done_at, done_cnt, addr_ok, tot_d, min_d, val_d);
      check("d_done_at",  32'(done_at), 7);
      check("d_done_cnt", 32'(done_cnt), 1);
      check("d_total",    32'(tot_d), 2);
      check("d_min",      32'(min_d), 2);
      check("d_minv",     32'(val_d), 1);
      load(0, 0, 0, 7);
      start_pulse();
      watch(9, 0, acc_hi, first_acc, done_at, done_cnt, addr_ok, tot_d, min_d, val_d);
      check("e_acc_cycles", 32'(acc_hi), 4);
      check("e_store_addr", 32'(addr_ok), 1);
      check("e_done_at",    32'(done_at), 7);
      check("e_done_cnt",   32'(done_cnt), 1);
      check("e_total",      32'(tot_d), 7);
      check("e_min",        32'(min_d), 7);
      check("e_minv",       32'(val_d), 1);
      check("gap_ge_2",     32'(min_gap >= 2), 1);
`ifdef CDF_SEQ_FRAME_CNT_EN
      check("e_frames", 32'(frame_count), 4);
`endif

      // Sweep F: synchronous reset at T+3, then sweep G {1,2,3,4}
      load(1, 2, 3, 4);
      start_pulse();
      @(negedge clock);
      @(negedge clock);
      @(negedge clock);
      reset = 1'b1;
      @(negedge clock);
      check_reset_outputs("f_rst");
      reset = 1'b0;
      start_pulse();
      watch(9, 0, acc_hi, first_acc, done_at, done_cnt, addr_ok, tot_d, min_d, val_d);
      check("g_done_at",  32'(done_at), 7);
      check("g_done_cnt", 32'(done_cnt), 1);
      check("g_total",    32'(tot_d), 10);
      check("g_min",      32'(min_d), 1);
      check("g_minv",     32'(val_d), 1);
`ifdef CDF_SEQ_FRAME_CNT_EN
      check("g_frames", 32'(frame_count), 1);
`endif

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

   initial begin
      #100000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

endmodule : tb_cdf_sequencer
`default_nettype wire
